// File: rtl/grid_cell_streamer_if.sv
// rtl/grid_cell_streamer_if.sv - classified-cell output stream between streamer and display driver
// Signals:
//   out_valid  master->slave  out_* holds a cell
//   out_ready  slave->master  sink accepts when out_valid & out_ready
//   out_cell   master->slave  00 empty, 01 body, 10 head, 11 apple
//   out_x      master->slave  column of out_cell
//   out_y      master->slave  row of out_cell
interface grid_cell_streamer_if;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_cell;
    logic [3:0] out_x;
    logic [3:0] out_y;

    modport master (
        output out_valid,
        output out_cell,
        output out_x,
        output out_y,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_cell,
        input  out_x,
        input  out_y,
        output out_ready
    );
endinterface

// File: rtl/grid_cell_streamer.sv
// rtl/grid_cell_streamer.sv - row-major grid sweep classifying each cell onto a valid/ready stream
// Ports:
//   system_clk  in   single clock, all state on posedge
//   nreset      in   synchronous active-low reset
//   start       in   frame request, honoured only in IDLE
//   x, y        out  query coordinates to the body wrapper
//   body, head  in   wrapper flags for the queried cell (combinational of x/y)
//   apple_x/_y  in   apple position
//   m_out       master side of the classified-cell stream
//   busy        out  high in SCAN and DRAIN
//   frame_done  out  one-cycle pulse, the cycle after the last cell is accepted
module grid_cell_streamer #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16
) (
    input  logic                        system_clk,
    input  logic                        nreset,
    input  logic                        start,
    output logic [3:0]                  x,
    output logic [3:0]                  y,
    input  logic                        body,
    input  logic                        head,
    input  logic [3:0]                  apple_x,
    input  logic [3:0]                  apple_y,
    grid_cell_streamer_if.master        m_out,
    output logic                        busy,
    output logic                        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic       r_out_valid;
    logic [1:0] r_out_cell;
    logic [3:0] r_out_x;
    logic [3:0] r_out_y;
    logic       r_frame_done;

    logic       w_accept;
    logic       w_capture;
    logic       w_last;
    logic       w_apple_hit;
    logic [1:0] w_cell;

    assign w_accept  = r_out_valid & m_out.out_ready;
    // The output register may be refilled when empty or when its cell leaves this cycle.
    assign w_capture = (r_state == ST_SCAN) & (~r_out_valid | w_accept);
    assign w_last    = (r_x == X_LAST) & (r_y == Y_LAST);
    // The counter never leaves the grid, so an out-of-grid apple can never match.
    assign w_apple_hit = (r_x == apple_x) & (r_y == apple_y);

    always_comb begin
        w_cell = 2'b00;
        if (head) begin
            w_cell = 2'b10;
        end else if (body) begin
            w_cell = 2'b01;
        end else if (w_apple_hit) begin
            w_cell = 2'b11;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // A start coinciding with frame_done belongs to the frame just finished.
            ST_IDLE:  if (start && !r_frame_done) w_state_nxt = ST_SCAN;
            ST_SCAN:  if (w_capture && w_last)    w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_accept)               w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_x          <= 4'd0;
            r_y          <= 4'd0;
            r_out_valid  <= 1'b0;
            r_out_cell   <= 2'b00;
            r_out_x      <= 4'd0;
            r_out_y      <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= (r_state == ST_DRAIN) & w_accept;
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_cell  <= w_cell;
                r_out_x     <= r_x;
                r_out_y     <= r_y;
                // Counter parks at (0,0) after the last cell so IDLE/DRAIN see zeros.
                if (w_last) begin
                    r_x <= 4'd0;
                    r_y <= 4'd0;
                end else if (r_x == X_LAST) begin
                    r_x <= 4'd0;
                    r_y <= r_y + 4'd1;
                end else begin
                    r_x <= r_x + 4'd1;
                end
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign x               = r_x;
    assign y               = r_y;
    assign m_out.out_valid = r_out_valid;
    assign m_out.out_cell  = r_out_cell;
    assign m_out.out_x     = r_out_x;
    assign m_out.out_y     = r_out_y;
    assign busy            = (r_state != ST_IDLE);
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_grid_cell_streamer.sv
// tb/tb_grid_cell_streamer.sv - directed self-checking bench for grid_cell_streamer (16x16 and 5x3)
module tb_grid_cell_streamer;

    logic       clk;
    logic       nreset;
    logic       start1, start2;
    logic [3:0] x1, y1, x2, y2;
    logic       body1, head1, body2, head2;
    logic [3:0] ax1, ay1, ax2, ay2;
    logic       busy1, fd1, busy2, fd2;
    logic [255:0] head_m, body_m;

    grid_cell_streamer_if if1 ();
    grid_cell_streamer_if if2 ();

    grid_cell_streamer #(.GRID_W(16), .GRID_H(16)) u_dut1 (
        .system_clk(clk), .nreset(nreset), .start(start1),
        .x(x1), .y(y1), .body(body1), .head(head1),
        .apple_x(ax1), .apple_y(ay1), .m_out(if1.master),
        .busy(busy1), .frame_done(fd1)
    );

    grid_cell_streamer #(.GRID_W(5), .GRID_H(3)) u_dut2 (
        .system_clk(clk), .nreset(nreset), .start(start2),
        .x(x2), .y(y2), .body(body2), .head(head2),
        .apple_x(ax2), .apple_y(ay2), .m_out(if2.master),
        .busy(busy2), .frame_done(fd2)
    );

    // Body wrapper models: combinational lookup of the queried cell.
    assign body1 = body_m[{y1, x1}];
    assign head1 = head_m[{y1, x1}];
    assign body2 = (x2 == 4'd4) && (y2 == 4'd2);
    assign head2 = (x2 == 4'd4) && (y2 == 4'd2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    logic       mon_clr;
    int         cyc = 0;
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    int busy_cnt, fd_cnt, last_acc, fd_cyc, fd2_cnt, max_x2, max_y2;

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            q1.delete(); q2.delete();
            busy_cnt = 0; fd_cnt = 0; last_acc = 0; fd_cyc = 0;
            fd2_cnt = 0; max_x2 = 0; max_y2 = 0;
        end else begin
            if (if1.out_valid && if1.out_ready) begin
                q1.push_back({if1.out_cell, if1.out_y, if1.out_x});
                last_acc = cyc;
            end
            if (busy1) busy_cnt++;
            if (fd1) begin fd_cnt++; fd_cyc = cyc; end
            if (if2.out_valid && if2.out_ready) q2.push_back({if2.out_cell, if2.out_y, if2.out_x});
            if (fd2) fd2_cnt++;
            if (int'(x2) > max_x2) max_x2 = int'(x2);
            if (int'(y2) > max_y2) max_y2 = int'(y2);
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        while (fd_cnt == 0 && n < 2000) begin
            @(negedge clk); #2;
            n++;
        end
        check(tag, int'(fd_cnt != 0), 1);
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic wait_out(input logic [3:0] wx, input logic [3:0] wy, input string tag);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 2000) begin
            @(negedge clk); #2;
            hit = if1.out_valid && (if1.out_x == wx) && (if1.out_y == wy);
            n++;
        end
        check(tag, int'(hit), 1);
    endtask

    function automatic logic [1:0] exp_cell(input int cx, input int cy);
        int idx = cy * 16 + cx;
        if (head_m[idx]) return 2'b10;
        if (body_m[idx]) return 2'b01;
        if (cx == int'(ax1) && cy == int'(ay1)) return 2'b11;
        return 2'b00;
    endfunction

    task automatic check_frame1(input string tag);
        int bad = 0;
        logic [9:0] e;
        check({tag, "_len"}, q1.size(), 256);
        for (int i = 0; i < q1.size() && i < 256; i++) begin
            e = {exp_cell(i % 16, i / 16), 4'(i / 16), 4'(i % 16)};
            if (q1[i] !== e) bad++;
        end
        check({tag, "_bad_cells"}, bad, 0);
    endtask

    initial begin
        nreset = 1'b0; start1 = 1'b0; start2 = 1'b0; mon_clr = 1'b1;
        if1.out_ready = 1'b1; if2.out_ready = 1'b1;
        head_m = '0; body_m = '0;
        ax1 = 4'd15; ay1 = 4'd15;
        ax2 = 4'd7;  ay2 = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(if1.out_valid), 0);
        check("rst_xy", int'({x1, y1}), 0);
        check("rst_out", int'({if1.out_cell, if1.out_x, if1.out_y}), 0);
        check("rst_busy_fd", int'({busy1, fd1}), 0);
        check("rst2_valid_busy", int'({if2.out_valid, busy2, fd2}), 0);
        nreset = 1'b1;
        clear_mon();

        // 1: empty grid (apple parked at 15,15), full-rate sink
        pulse_start1();
        wait_fd("t1_done");
        check_frame1("t1");
        if (q1.size() == 256) begin
            check("t1_first", int'(q1[0]), 0);
            check("t1_last", int'(q1[255]), int'({2'b11, 4'd15, 4'd15}));
        end
        check("t1_fd_count", fd_cnt, 1);
        check("t1_fd_latency", fd_cyc - last_acc, 1);
        check("t1_busy_cycles", busy_cnt, 257);
        check("t1_idle_xy", int'({x1, y1}), 0);

        // 2: snake at row 2, apple at (9,9)
        head_m[35] = 1'b1; body_m[34] = 1'b1; body_m[33] = 1'b1;
        ax1 = 4'd9; ay1 = 4'd9;
        clear_mon();
        pulse_start1();
        wait_fd("t2_done");
        check_frame1("t2");
        if (q1.size() == 256) begin
            check("t2_c35", int'(q1[35][9:8]), 2);
            check("t2_c34", int'(q1[34][9:8]), 1);
            check("t2_c33", int'(q1[33][9:8]), 1);
            check("t2_c153", int'(q1[153][9:8]), 3);
            check("t2_c36", int'(q1[36][9:8]), 0);
        end

        // 3: five-cycle stall while (7,0) is presented
        clear_mon();
        pulse_start1();
        wait_out(4'd6, 4'd0, "t3_reach");
        @(posedge clk); #1 if1.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            check("t3_hold", int'({if1.out_valid, if1.out_y, if1.out_x, x1}),
                  int'({1'b1, 4'd0, 4'd7, 4'd8}));
        end
        @(posedge clk); #1 if1.out_ready = 1'b1;
        wait_fd("t3_done");
        check_frame1("t3");

        // 4: reset mid-frame
        clear_mon();
        pulse_start1();
        wait_out(4'd4, 4'd5, "t4_reach");
        @(posedge clk); #1 nreset = 1'b0;
        @(posedge clk); #1;
        check("t4_rst_state", int'({busy1, if1.out_valid, x1, y1}), 0);
        nreset = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        #2;
        check("t4_no_fd", fd_cnt, 0);
        check("t4_no_cells", q1.size(), 0);
        pulse_start1();
        wait_fd("t4_done");
        check_frame1("t4");

        // 5: start during SCAN and on the frame_done cycle is ignored
        clear_mon();
        pulse_start1();
        wait_out(4'd5, 4'd0, "t5_reach");
        pulse_start1();
        wait_out(4'd15, 4'd15, "t5_last");
        @(posedge clk); #1 start1 = 1'b1;
        check("t5_fd_cycle", int'(fd1), 1);
        @(posedge clk); #1 start1 = 1'b0;
        check("t5_busy_after", int'(busy1), 0);
        repeat (5) @(negedge clk);
        #2;
        check("t5_fd_count", fd_cnt, 1);
        check("t5_len", q1.size(), 256);
        check("t5_still_idle", int'(busy1), 0);
        clear_mon();
        pulse_start1();
        check("t5_restart_busy", int'(busy1), 1);
        wait_fd("t5_done2");
        check_frame1("t5b");

        // 6: 5x3 grid, head+body on the last cell, apple outside the grid
        clear_mon();
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        begin
            int n = 0;
            while (fd2_cnt == 0 && n < 200) begin
                @(negedge clk); #2;
                n++;
            end
        end
        repeat (3) @(negedge clk);
        #2;
        check("t6_fd_count", fd2_cnt, 1);
        check("t6_len", q2.size(), 15);
        begin
            int bad = 0;
            logic [9:0] e;
            for (int i = 0; i < q2.size() && i < 15; i++) begin
                e = {(i == 14) ? 2'b10 : 2'b00, 4'(i / 5), 4'(i % 5)};
                if (q2[i] !== e) bad++;
            end
            check("t6_bad_cells", bad, 0);
        end
        if (q2.size() == 15) check("t6_last", int'(q2[14]), int'({2'b10, 4'd2, 4'd4}));
        check("t6_max_x", max_x2, 4);
        check("t6_max_y", max_y2, 2);
        check("t6_idle", int'({busy2, if2.out_valid}), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
